framebuffer_scanout: RTL and testbench
======================================

// Module: framebuffer_scanout
// PURPOSE
// - Read side of the 640x480, 3-bit-per-pixel frame buffer that the drawing logic writes.
// - Generates VGA timing, sweeps read addresses in raster order and drives the pixel and sync outputs.
// - Reports vertical blanking so drawing can be scheduled outside active video.
// - Sits between the frame buffer read port (synchronous RAM, 1-cycle read latency) and the VGA DAC pins.
// PARAMETERS
// - H_ACTIVE  640  visible pixels per line
// - H_FP       16  horizontal front porch, in clocks
// - H_SYNC     96  hsync pulse width, in clocks
// - H_BP       48  horizontal back porch, in clocks
// - V_ACTIVE  480  visible lines
// - V_FP       10  vertical front porch, in lines
// - V_SYNC      2  vsync pulse width, in lines
// - V_BP       33  vertical back porch, in lines
// - ADDR_W     19  frame buffer address width
// - PIX_W       3  pixel data width
// PORTS
// - clock        in   1       pixel clock; all logic on posedge
// - reset        in   1       synchronous, active-high
// - mem_raddr    out  ADDR_W  frame buffer read address
// - mem_renable  out  1       read strobe; high only for active-region addresses
// - mem_rdata    in   PIX_W   read data, valid one clock after mem_raddr/mem_renable
// - pix_out      out  PIX_W   pixel to DAC; 0 while blanked
// - hsync        out  1       active-low horizontal sync
// - vsync        out  1       active-low vertical sync
// - video_on     out  1       high during the visible region (aligned with pix_out)
// - in_vblank    out  1       high from line V_ACTIVE through end of frame (aligned with pix_out)
// - frame_done   out  1       1-clock pulse on the first pixel time of line V_ACTIVE (aligned with pix_out)
// - test_pattern in   1       selects colour bars; present only with the macro enabled
// BEHAVIOUR
// - Counters:
//   - hcnt runs 0..H_TOTAL-1, with H_TOTAL = sum of the H_* parameters (800).
//   - vcnt runs 0..V_TOTAL-1 (525) and advances when hcnt wraps.
//   - Both counters wrap to 0 together at (799, 524).
// - Active region: hcnt < H_ACTIVE && vcnt < V_ACTIVE.
// - Read pointer:
//   - Running ADDR_W-bit pointer, incremented once per active clock.
//   - Cleared on counter wrap to (0, 0).
//   - No multiplier.
//   - Runs 0..307199 per frame and never overflows ADDR_W.
// - Pipeline:
//   - Stage 1 registers mem_raddr = pointer and mem_renable = active.
//   - Stage 2: RAM returns data; pix_out = video_on_d ? mem_rdata : 0.
//   - hsync, vsync, video_on, in_vblank and frame_done are delayed two clocks from the counters so they align with pix_out.
//   - Total latency from counter value to pin is 2 clocks.
// - Sync windows:
//   - hsync is low for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
//   - vsync is low for the equivalent range of vcnt.
// - Blanking: pix_out is forced to 0 whenever video_on is low, regardless of mem_rdata.
// - Reset values:
//   - Counters and pointer: 0.
//   - mem_raddr: 0. mem_renable: 0. pix_out: 0.
//   - hsync: 1. vsync: 1. video_on: 0. in_vblank: 0. frame_done: 0.
//   - All pipeline delay registers are cleared.
// - Reset mid-frame: outputs take their reset values on the next edge. After release, the block restarts at (0, 0) with pointer 0. No partial-line data is emitted.
// - The block has no backpressure: the read port must accept one read per clock.
// - Reads never alias writes; arbitration is handled outside this block.
// CONFIGURATION
// - SCANOUT_TEST_PATTERN_EN defined:
//   - test_pattern port exists.
//   - While test_pattern is 1, pix_out = hcnt_d[9:7] during video_on; mem_renable stays 0.
//   - Timing is unchanged.
// - SCANOUT_TEST_PATTERN_EN undefined: no test_pattern port; pixels always come from memory.
// TESTING
// - Reset values: hold reset 3 clocks -> all outputs at reset values; first mem_renable=1 occurs 1 clock after release, with mem_raddr=0.
// - Horizontal timing: run 2 lines -> hsync low for exactly 96 clocks, period 800; video_on high 640 clocks per line.
// - Vertical timing and addressing: run 1 frame ->
//   - vsync low for exactly 1600 clocks; line 1 starts at address 640; last address is 307199; next frame restarts at 0.
//   - frame_done pulses exactly once per 420000 clocks; in_vblank is high for 45 lines.
// - Data alignment: RAM model returns addr[2:0] -> pix_out at first visible pixel = 0, second = 1; pix_out = 0 through all blanking.
// - Reset mid-frame: assert reset at (hcnt=300, vcnt=200) for 1 clock -> restart at (0, 0); mem_raddr sequence resumes from 0.
// - Macro build: define SCANOUT_TEST_PATTERN_EN, test_pattern=1 -> pix_out steps 0..4 every 128 visible pixels; mem_renable stays 0.

Source files
------------

// File: rtl/framebuffer_scanout.sv
// VGA scanout for a 640x480, 3-bit frame buffer: raster timing, read address sweep,
// two-stage pipeline to the DAC pins. Optional colour bars via SCANOUT_TEST_PATTERN_EN.
module framebuffer_scanout #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int ADDR_W   = 19,
   parameter int PIX_W    = 3
) (
   input  logic              clock,
   input  logic              reset,
   output logic [ADDR_W-1:0] mem_raddr,
   output logic              mem_renable,
   input  logic [PIX_W-1:0]  mem_rdata,
   output logic [PIX_W-1:0]  pix_out,
   output logic              hsync,
   output logic              vsync,
   output logic              video_on,
   output logic              in_vblank,
   output logic              frame_done
`ifdef SCANOUT_TEST_PATTERN_EN
  ,input  logic              test_pattern
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HV_MAX  = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
   // At least 10 bits so the colour-bar select hcnt[9:7] always exists.
   localparam int CNT_W   = ($clog2(HV_MAX) > 10) ? $clog2(HV_MAX) : 10;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [CNT_W-1:0]  hcnt;
   logic [CNT_W-1:0]  vcnt;
   logic [ADDR_W-1:0] ptr;
   logic              h_wrap;
   logic              frame_wrap;
   logic              active;
   logic              hs_now;
   logic              vs_now;
   logic              vblank_now;
   logic              fdone_now;
   logic              tp_now;
   logic              von_d1;
   logic              hs_d1;
   logic              vs_d1;
   logic              vbl_d1;
   logic              fd_d1;

   assign h_wrap     = (hcnt == H_LAST);
   assign frame_wrap = h_wrap && (vcnt == V_LAST);
   assign active     = (hcnt < H_VIS) && (vcnt < V_VIS);
   assign hs_now     = !((hcnt >= HS_BEG) && (hcnt < HS_END));
   assign vs_now     = !((vcnt >= VS_BEG) && (vcnt < VS_END));
   assign vblank_now = (vcnt >= V_VIS);
   assign fdone_now  = (vcnt == V_VIS) && (hcnt == {CNT_W{1'b0}});

   // Raster counters and the running read pointer (address = visible pixels so far this frame).
   always_ff @(posedge clock) begin
      if (reset) begin
         hcnt <= '0;
         vcnt <= '0;
         ptr  <= '0;
      end else begin
         if (h_wrap) begin
            hcnt <= '0;
            if (vcnt == V_LAST) begin
               vcnt <= '0;
            end else begin
               vcnt <= vcnt + CNT_W'(1);
            end
         end else begin
            hcnt <= hcnt + CNT_W'(1);
         end
         if (frame_wrap) begin
            ptr <= '0;
         end else if (active) begin
            ptr <= ptr + ADDR_W'(1);
         end else begin
            ptr <= ptr;
         end
      end
   end

   // Stage 1: issue the read and carry the timing flags alongside it.
   always_ff @(posedge clock) begin
      if (reset) begin
         mem_raddr   <= '0;
         mem_renable <= 1'b0;
         von_d1      <= 1'b0;
         hs_d1       <= 1'b1;
         vs_d1       <= 1'b1;
         vbl_d1      <= 1'b0;
         fd_d1       <= 1'b0;
      end else begin
         mem_raddr   <= ptr;
         mem_renable <= active && !tp_now;
         von_d1      <= active;
         hs_d1       <= hs_now;
         vs_d1       <= vs_now;
         vbl_d1      <= vblank_now;
         fd_d1       <= fdone_now;
      end
   end

   // Stage 2: timing flags land on the pins in the same clock the RAM data arrives.
   always_ff @(posedge clock) begin
      if (reset) begin
         video_on   <= 1'b0;
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         in_vblank  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         video_on   <= von_d1;
         hsync      <= hs_d1;
         vsync      <= vs_d1;
         in_vblank  <= vbl_d1;
         frame_done <= fd_d1;
      end
   end

`ifdef SCANOUT_TEST_PATTERN_EN
   logic       tp_d1;
   logic       tp_d2;
   logic [2:0] bar_d1;
   logic [2:0] bar_d2;

   assign tp_now = test_pattern;

   // Colour-bar select and its enable follow the same two-stage delay as video_on.
   always_ff @(posedge clock) begin
      if (reset) begin
         tp_d1  <= 1'b0;
         tp_d2  <= 1'b0;
         bar_d1 <= 3'd0;
         bar_d2 <= 3'd0;
      end else begin
         tp_d1  <= test_pattern;
         tp_d2  <= tp_d1;
         bar_d1 <= hcnt[9:7];
         bar_d2 <= bar_d1;
      end
   end

   // The RAM output is itself the second register stage, so only the blanking gate is here.
   always_comb begin
      pix_out = '0;
      if (!video_on) begin
         pix_out = '0;
      end else if (tp_d2) begin
         pix_out = PIX_W'(bar_d2);
      end else begin
         pix_out = mem_rdata;
      end
   end
`else
   assign tp_now = 1'b0;

   // The RAM output is itself the second register stage, so only the blanking gate is here.
   always_comb begin
      pix_out = '0;
      if (video_on) begin
         pix_out = mem_rdata;
      end else begin
         pix_out = '0;
      end
   end
`endif

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout: boundary table, frame statistics, mid-frame reset and a
// random-reset soak, all against an arithmetic raster model. Build with SCANOUT_TEST_PATTERN_EN for bars.
module tb_framebuffer_scanout;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int V_ACTIVE = 10;
   localparam int V_FP     = 2;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 2;
   localparam int ADDR_W   = 19;
   localparam int PIX_W    = 3;
   localparam int H_TOTAL  = 800;
   localparam int V_TOTAL  = 16;
   localparam int FRAME    = H_TOTAL * V_TOTAL;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              tp = 1'b0;
   logic [ADDR_W-1:0] mem_raddr;
   logic              mem_renable;
   logic [PIX_W-1:0]  mem_rdata = '0;
   logic [PIX_W-1:0]  pix_out;
   logic              hsync, vsync, video_on, in_vblank, frame_done;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;
   bit stat_en = 1'b0;

   always #5 clock = ~clock;

   framebuffer_scanout #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .ADDR_W(ADDR_W), .PIX_W(PIX_W)
   ) dut (
      .clock(clock), .reset(reset),
      .mem_raddr(mem_raddr), .mem_renable(mem_renable), .mem_rdata(mem_rdata),
      .pix_out(pix_out), .hsync(hsync), .vsync(vsync), .video_on(video_on),
      .in_vblank(in_vblank), .frame_done(frame_done)
`ifdef SCANOUT_TEST_PATTERN_EN
     ,.test_pattern(tp)
`endif
   );

   // RAM: returns addr[2:0] one clock after an enabled read, garbage otherwise.
   always @(posedge clock) begin
      if (mem_renable) mem_rdata <= mem_raddr[2:0];
      else             mem_rdata <= 3'($urandom);
   end

   // Reference model state: e = clock edges since reset release = current raster index.
   int   e = 0;
   logic tp1_m = 1'b0;
   logic tp2_m = 1'b0;
   always @(posedge clock) begin
      if (reset) begin
         e <= 0; tp1_m <= 1'b0; tp2_m <= 1'b0;
      end else begin
         e <= e + 1; tp1_m <= tp; tp2_m <= tp1_m;
      end
   end

   function automatic int hpos(input int j); return j % H_TOTAL; endfunction
   function automatic int vpos(input int j); return (j / H_TOTAL) % V_TOTAL; endfunction
   function automatic bit act(input int j);
      return (hpos(j) < H_ACTIVE) && (vpos(j) < V_ACTIVE);
   endfunction
   // Number of visible pixels preceding raster index j in its frame.
   function automatic int ptr_at(input int j);
      int h, v;
      h = hpos(j); v = vpos(j);
      if (v >= V_ACTIVE) return V_ACTIVE * H_ACTIVE;
      return v * H_ACTIVE + ((h < H_ACTIVE) ? h : H_ACTIVE);
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   task automatic wait_e(input int target, input string name);
      int budget;
      budget = 40000;
      while (e != target && budget > 0) begin
         @(negedge clock);
         budget--;
      end
      if (e != target) begin
         tests++; fails++;
         $display("FAIL %s: timeout at index %0d, expected index %0d", name, e, target);
      end
   endtask

   // Cycle-by-cycle comparison of every output against the model.
   initial begin : cycle_checker
      int j, h, v;
      logic [18:0] w_raddr;
      logic w_ren, w_hs, w_vs, w_von, w_vbl, w_fd;
      logic [2:0] w_pix;
      logic [27:0] got, want;
      forever begin
         @(negedge clock);
         if (chk_en) begin
            if (e >= 1) begin
               w_raddr = 19'(ptr_at(e - 1));
               w_ren   = act(e - 1) && !tp1_m;
            end else begin
               w_raddr = '0; w_ren = 1'b0;
            end
            if (e >= 2) begin
               j = e - 2; h = hpos(j); v = vpos(j);
               w_hs  = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
               w_vs  = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
               w_von = act(j);
               w_vbl = (v >= V_ACTIVE);
               w_fd  = (v == V_ACTIVE) && (h == 0);
               if (!w_von)     w_pix = 3'd0;
               else if (tp2_m) w_pix = 3'(h / 128);
               else            w_pix = 3'(ptr_at(j));
            end else begin
               w_hs = 1'b1; w_vs = 1'b1; w_von = 1'b0; w_vbl = 1'b0; w_fd = 1'b0; w_pix = 3'd0;
            end
            got  = {mem_raddr, mem_renable, pix_out, hsync, vsync, video_on, in_vblank, frame_done};
            want = {w_raddr, w_ren, w_pix, w_hs, w_vs, w_von, w_vbl, w_fd};
            tests++;
            if (got !== want) begin
               fails++;
               $display("FAIL cycle idx=%0d: got %h, expected %h", e, got, want);
            end
         end
      end
   end

   // First-frame statistics gathered while stat_en is set.
   int hs_low = 0, vs_low = 0, fd_cnt = 0, vbl_cnt = 0, von_cnt = 0;
   int last_addr = -1, line1_addr = -1, restart_addr = -1;
   logic restart_ren = 1'b0;
   initial begin : frame_stats
      forever begin
         @(negedge clock);
         if (stat_en) begin
            if (e >= 2 && e < FRAME + 2) begin
               hs_low  += int'(!hsync);
               vs_low  += int'(!vsync);
               fd_cnt  += int'(frame_done);
               vbl_cnt += int'(in_vblank);
               von_cnt += int'(video_on);
            end
            if (mem_renable && e >= 1 && e <= FRAME) begin
               if (int'(mem_raddr) > last_addr) last_addr = int'(mem_raddr);
               if (e == H_TOTAL + 1) line1_addr = int'(mem_raddr);
            end
            if (e == FRAME + 1) begin
               restart_addr = int'(mem_raddr);
               restart_ren  = mem_renable;
            end
         end
      end
   end

   typedef struct {
      int h; int v;
      logic hs; logic vs; logic von; logic vbl; logic fd; logic [2:0] pix;
   } vec_t;
   vec_t tbl[18];

   initial begin
      tbl[0]  = '{0,   0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
      tbl[1]  = '{639, 0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd7};
      tbl[2]  = '{640, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
      tbl[3]  = '{655, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
      tbl[4]  = '{656, 0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
      tbl[5]  = '{751, 0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
      tbl[6]  = '{752, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
      tbl[7]  = '{799, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
      tbl[8]  = '{0,   1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
      tbl[9]  = '{639, 9,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd7};
      tbl[10] = '{0,   10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0};
      tbl[11] = '{1,   10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
      tbl[12] = '{799, 11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
      tbl[13] = '{0,   12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
      tbl[14] = '{700, 13, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
      tbl[15] = '{0,   14, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
      tbl[16] = '{799, 15, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
      tbl[17] = '{0,   16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};

      // Reset held for three clocks.
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk_en = 1'b1;
      check("rst_raddr", 32'(mem_raddr), 32'd0);
      check("rst_renable", 32'(mem_renable), 32'd0);
      check("rst_pix", 32'(pix_out), 32'd0);
      check("rst_sync", {30'd0, hsync, vsync}, 32'd3);
      check("rst_flags", {29'd0, video_on, in_vblank, frame_done}, 32'd0);

      reset = 1'b0;
      stat_en = 1'b1;
      @(negedge clock);
      check("first_read_en", 32'(mem_renable), 32'd1);
      check("first_read_addr", 32'(mem_raddr), 32'd0);

      // Boundary table across the first frame and into the second.
      for (int i = 0; i < 18; i++) begin
         wait_e(tbl[i].v * H_TOTAL + tbl[i].h + 2, "table_wait");
         check($sformatf("vec%0d_h%0d_v%0d", i, tbl[i].h, tbl[i].v),
               {24'd0, hsync, vsync, video_on, in_vblank, frame_done, pix_out},
               {24'd0, tbl[i].hs, tbl[i].vs, tbl[i].von, tbl[i].vbl, tbl[i].fd, tbl[i].pix});
      end
      stat_en = 1'b0;
      check("hsync_low_frame", 32'(hs_low), 32'd1536);
      check("vsync_low_frame", 32'(vs_low), 32'd1600);
      check("frame_done_count", 32'(fd_cnt), 32'd1);
      check("vblank_clocks", 32'(vbl_cnt), 32'd4800);
      check("video_on_clocks", 32'(von_cnt), 32'd6400);
      check("line1_addr", 32'(line1_addr), 32'd640);
      check("last_addr", 32'(last_addr), 32'd6399);
      check("restart_addr", {31'(restart_addr), restart_ren}, {31'd0, 1'b1});

      // One-clock reset at (300, 5) of the second frame.
      wait_e(FRAME + 5 * H_TOTAL + 300, "midreset_wait");
      reset = 1'b1;
      @(negedge clock);
      check("mid_rst_video", {29'd0, video_on, hsync, mem_renable}, 32'd2);
      check("mid_rst_addr", 32'(mem_raddr), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      check("mid_restart", {12'd0, mem_raddr, mem_renable}, 32'd1);
      @(negedge clock);
      check("mid_next_addr", 32'(mem_raddr), 32'd1);
      check("mid_no_partial", 32'(pix_out), 32'd0);

`ifdef SCANOUT_TEST_PATTERN_EN
      // Colour bars across one full visible line.
      wait_e(3 * H_TOTAL, "bars_wait");
      tp = 1'b1;
      for (int p = 0; p < H_TOTAL; p++) begin
         @(negedge clock);
         check("bars_renable", 32'(mem_renable), 32'd0);
         if (p == 0 || p == 127 || p == 128 || p == 256 || p == 384 || p == 512 || p == 639) begin
            @(negedge clock);
            p++;
            check($sformatf("bars_pix%0d", p - 1), 32'(pix_out), 32'((p - 1) / 128));
            check("bars_renable", 32'(mem_renable), 32'd0);
         end
      end
      tp = 1'b0;
`endif

      // Random soak: sporadic resets (and bar toggles) against the model.
      for (int c = 0; c < 30000; c++) begin
         @(negedge clock);
         if ($urandom_range(0, 3999) == 0) begin
            reset = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clock);
            reset = 1'b0;
         end
`ifdef SCANOUT_TEST_PATTERN_EN
         if ($urandom_range(0, 1499) == 0) tp = ~tp;
`endif
      end
      @(negedge clock);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
